// File: rtl/seq_divider_36x18_if.sv
// Operand/result bundle for the sequential 36/18 unsigned divider.
// The master drives the request and operands; the slave (the divider)
// returns the busy/done handshake and the registered results.
interface seq_divider_36x18_if #(
    parameter int DIVIDEND_W = 36,
    parameter int DIVISOR_W  = 18
);
    logic                  start;
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
    logic                  busy;
    logic                  done;
    logic [DIVIDEND_W-1:0] quotient;
    logic [DIVISOR_W-1:0]  remainder;
    logic                  div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider_36x18.sv
// Multi-cycle unsigned restoring divider, fabric logic only.
// One quotient bit per clock: a 36-bit dividend over an 18-bit divisor
// completes in 36 iterations; divide-by-zero is resolved in one cycle.
// The dividend register doubles as the quotient shift register: each
// iteration shifts its MSB into the partial remainder and shifts the new
// quotient bit into its LSB.
module seq_divider_36x18 #(
    parameter int DIVIDEND_W = 36,
    parameter int DIVISOR_W  = 18
) (
    input  logic                clk,
    input  logic                rst,
    seq_divider_36x18_if.slave  bus
);

    localparam int CNT_W = $clog2(DIVIDEND_W);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t                state_r, state_s;
    logic [DIVIDEND_W-1:0] work_r, work_s;
    logic [DIVISOR_W-1:0]  dvsr_r, dvsr_s;
    logic [DIVISOR_W:0]    prem_r, prem_s;
    logic [CNT_W-1:0]      cnt_r, cnt_s;
    logic                  busy_r, busy_s;
    logic                  done_r, done_s;
    logic                  dbz_r, dbz_s;
    logic [DIVIDEND_W-1:0] quot_r, quot_s;
    logic [DIVISOR_W-1:0]  rem_r, rem_s;

    // one restoring-division step
    logic [DIVISOR_W+1:0]  shifted_s;
    logic [DIVISOR_W:0]    diff_s;
    logic                  ge_s;
    logic [DIVISOR_W:0]    prem_step_s;
    logic [DIVIDEND_W-1:0] work_step_s;

    // Datapath: shift in the next dividend bit, trial-subtract, restore on borrow.
    always_comb begin
        shifted_s = {prem_r, work_r[DIVIDEND_W-1]};
        ge_s      = (shifted_s >= {2'b00, dvsr_r});
        // Only used when ge_s: shifted < 2*divisor, so the difference fits.
        diff_s    = shifted_s[DIVISOR_W:0] - {1'b0, dvsr_r};
        if (ge_s) begin
            prem_step_s = diff_s;
        end else begin
            prem_step_s = shifted_s[DIVISOR_W:0];
        end
        work_step_s = {work_r[DIVIDEND_W-2:0], ge_s};
    end

    // Next-state and next-register logic for the IDLE/RUN/FINISH controller.
    always_comb begin
        state_s = state_r;
        work_s  = work_r;
        dvsr_s  = dvsr_r;
        prem_s  = prem_r;
        cnt_s   = cnt_r;
        busy_s  = busy_r;
        done_s  = 1'b0;
        dbz_s   = dbz_r;
        quot_s  = quot_r;
        rem_s   = rem_r;

        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    work_s = bus.dividend;
                    dvsr_s = bus.divisor;
                    prem_s = {(DIVISOR_W+1){1'b0}};
                    cnt_s  = CNT_W'(DIVIDEND_W - 1);
                    dbz_s  = 1'b0;
                    busy_s = 1'b1;
                    if (bus.divisor != {DIVISOR_W{1'b0}}) begin
                        state_s = RUN;
                    end else begin
                        state_s = FINISH;
                    end
                end else begin
                    state_s = IDLE;
                    busy_s  = 1'b0;
                end
            end
            RUN: begin
                prem_s = prem_step_s;
                work_s = work_step_s;
                cnt_s  = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_r == {CNT_W{1'b0}}) begin
                    quot_s  = work_step_s;
                    rem_s   = prem_step_s[DIVISOR_W-1:0];
                    done_s  = 1'b1;
                    busy_s  = 1'b0;
                    state_s = IDLE;
                end else begin
                    state_s = RUN;
                end
            end
            FINISH: begin
                // Divide by zero: saturate quotient, pass low dividend bits through.
                quot_s  = {DIVIDEND_W{1'b1}};
                rem_s   = work_r[DIVISOR_W-1:0];
                dbz_s   = 1'b1;
                done_s  = 1'b1;
                busy_s  = 1'b0;
                state_s = IDLE;
            end
            default: begin
                busy_s  = 1'b0;
                state_s = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset that aborts any operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            work_r  <= {DIVIDEND_W{1'b0}};
            dvsr_r  <= {DIVISOR_W{1'b0}};
            prem_r  <= {(DIVISOR_W+1){1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            dbz_r   <= 1'b0;
            quot_r  <= {DIVIDEND_W{1'b0}};
            rem_r   <= {DIVISOR_W{1'b0}};
        end else begin
            state_r <= state_s;
            work_r  <= work_s;
            dvsr_r  <= dvsr_s;
            prem_r  <= prem_s;
            cnt_r   <= cnt_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            dbz_r   <= dbz_s;
            quot_r  <= quot_s;
            rem_r   <= rem_s;
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.div_by_zero = dbz_r;
    assign bus.quotient    = quot_r;
    assign bus.remainder   = rem_r;

endmodule

// File: tb/tb_seq_divider_36x18.sv
// Scoreboard bench for seq_divider_36x18: the driver pushes the expected
// result (from plain / and %) per accepted start; an independent monitor
// pops and compares at every done pulse, including latency.
module tb_seq_divider_36x18;

    localparam int DW = 36;
    localparam int VW = 18;
    localparam int N_RAND = 1400;

    typedef struct {
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        logic          dbz;
        logic [DW-1:0] dd;
        logic [VW-1:0] dv;
        int            issue;
        int            lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    exp_t sb[$];

    seq_divider_36x18_if #(.DIVIDEND_W(DW), .DIVISOR_W(VW)) bus ();

    seq_divider_36x18 #(.DIVIDEND_W(DW), .DIVISOR_W(VW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: plain unsigned arithmetic.
    function automatic exp_t model(input logic [DW-1:0] dd, input logic [VW-1:0] dv, input int issue);
        exp_t e;
        e.dd = dd;
        e.dv = dv;
        e.issue = issue;
        if (dv == 0) begin
            e.q   = {DW{1'b1}};
            e.r   = dd[VW-1:0];
            e.dbz = 1'b1;
            e.lat = 1;
        end else begin
            e.q   = dd / {18'd0, dv};
            e.r   = VW'(dd % {18'd0, dv});
            e.dbz = 1'b0;
            e.lat = DW;
        end
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                logic [63:0] prod;
                e = sb.pop_front();
                check("quotient", 64'(bus.quotient), 64'(e.q));
                check("remainder", 64'(bus.remainder), 64'(e.r));
                check("div_by_zero", 64'(bus.div_by_zero), 64'(e.dbz));
                check("latency", 64'(cyc - e.issue), 64'(e.lat));
                check("busy_at_done", 64'(bus.busy), 64'd0);
                if (!e.dbz) begin
                    prod = 64'(bus.quotient) * 64'(e.dv) + 64'(bus.remainder);
                    check("invariant", prod, 64'(e.dd));
                    check("rem_lt_div", 64'(bus.remainder < e.dv), 64'd1);
                end
            end
        end
    end

    // Issue one request as soon as the divider is free (may be the done cycle).
    task automatic issue(input logic [DW-1:0] dd, input logic [VW-1:0] dv);
        int n = 0;
        while (bus.busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) check("wait_not_busy_timeout", 64'd1, 64'd0);
        bus.dividend = dd;
        bus.divisor  = dv;
        bus.start    = 1'b1;
        sb.push_back(model(dd, dv, cyc + 1));
        @(negedge clk);
        bus.start    = 1'b0;
        bus.dividend = {DW{1'b0}};
        bus.divisor  = {VW{1'b0}};
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_busy"}, 64'(bus.busy), 64'd0);
        check({tag, "_done"}, 64'(bus.done), 64'd0);
        check({tag, "_quotient"}, 64'(bus.quotient), 64'd0);
        check({tag, "_remainder"}, 64'(bus.remainder), 64'd0);
        check({tag, "_dbz"}, 64'(bus.div_by_zero), 64'd0);
    endtask

    initial begin
        logic [63:0]   t;
        logic [DW-1:0] dd;
        logic [VW-1:0] dv;
        int            n;

        bus.start    = 1'b0;
        bus.dividend = {DW{1'b0}};
        bus.divisor  = {VW{1'b0}};
        repeat (3) @(negedge clk);
        check_idle_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Directed cases.
        issue(36'd100, 18'd7);
        drain();
        issue(36'h3FFFC0001, 18'h1FFFF);
        issue(36'hFFFFFFFFF, 18'd1);
        issue(36'h123456789, 18'd0);
        issue(36'd5, 18'd9);
        issue(36'hFFFFFFFFF, 18'h3FFFF);
        issue(36'd0, 18'd3);
        drain();

        // Start while busy is ignored; exactly one done follows.
        issue(36'd1000, 18'd33);
        repeat (9) @(negedge clk);
        bus.dividend = 36'h0ABCDEF01;
        bus.divisor  = 18'd5;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start    = 1'b0;
        drain();
        repeat (40) @(negedge clk);

        // Reset in the middle of an operation aborts it.
        issue(36'h876543210, 18'd1234);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        sb.delete();
        check_idle_zero("midrun_reset");
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("no_done_after_abort", 64'(bus.done), 64'd0);
        issue(36'd77777, 18'd77);
        drain();

        // Start held high through done: second op begins on the done edge.
        bus.dividend = 36'h0DEADBEEF;
        bus.divisor  = 18'd4097;
        bus.start    = 1'b1;
        sb.push_back(model(36'h0DEADBEEF, 18'd4097, cyc + 1));
        @(negedge clk);
        n = 0;
        while (!bus.done && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("held_start_first_done", 64'(bus.done), 64'd1);
        bus.dividend = 36'h0000F00D5;
        bus.divisor  = 18'd13;
        sb.push_back(model(36'h0000F00D5, 18'd13, cyc + 1));
        @(negedge clk);
        bus.start = 1'b0;
        drain();

        // Randomized operands with forced corner divisors.
        for (int i = 0; i < N_RAND; i++) begin
            t  = {$urandom(), $urandom()};
            dd = t[DW-1:0];
            dv = VW'($urandom());
            case ($urandom_range(0, 7))
                0: dv = 18'd1;
                1: dv = 18'h3FFFF;
                2: dv = 18'd0;
                3: begin
                    if (dv == 0) dv = 18'd9;
                    dd = DW'($urandom_range(0, 1000)) % DW'(dv);
                end
                4: dd = DW'(t[17:0]) * DW'(t[35:18]);
                default: dv = dv;
            endcase
            issue(dd, dv);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        drain();
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
